// File: rtl/uart_cmd_rx.sv
// Serial command receiver: 8N1 UART deserialiser plus a 4-byte frame parser
// (A5, CMD, IDX, CMD^IDX). Accepted commands become one-cycle control pulses.
module uart_cmd_rx #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 115_200,
    parameter int NUM_OF_MODULES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX,
    output logic [NUM_OF_MODULES-1:0] res,
    output logic                      start_all,
    output logic                      cmd_ok,
    output logic                      cmd_err,
    output logic                      frame_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_START   = 8'h01;
    localparam logic [7:0] CMD_RES_ONE = 8'h02;
    localparam logic [7:0] CMD_RES_ALL = 8'h03;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {P_WAIT_SYNC, P_GET_CMD, P_GET_IDX, P_GET_CHK} p_state_e;

    logic rx_meta_q, rx_sync_q;

    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       rx_byte_q;
    logic             byte_valid_q;
    logic             frame_err_q;
    logic             stop_bad;

    p_state_e                  p_state_q;
    logic [7:0]                cmd_q, idx_q;
    logic [NUM_OF_MODULES-1:0] idx_hit;
    logic [NUM_OF_MODULES-1:0] res_d, res_q;
    logic                      start_d, start_q;
    logic                      ok_d, ok_q;
    logic                      err_d, err_q;

    // Line idles high, so both synchroniser stages come out of reset as 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign stop_bad = (rx_state_q == RX_STOP) && (cnt_q == BIT_LAST) && !rx_sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= RX_START;
                        cnt_q      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q        <= '0;
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                        rx_state_q   <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OF_MODULES; i++) idx_hit[i] = (idx_q == 8'(i));
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        res_d   = '0;
        start_d = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        if (byte_valid_q && p_state_q == P_GET_CHK) begin
            if (rx_byte_q != (cmd_q ^ idx_q)) begin
                err_d = 1'b1;
            end else begin
                unique case (cmd_q)
                    CMD_START: begin
                        start_d = 1'b1;
                        ok_d    = 1'b1;
                    end
                    CMD_RES_ONE: begin
                        // idx_hit is all-zero exactly when IDX is out of range.
                        if (|idx_hit) begin
                            res_d = idx_hit;
                            ok_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_RES_ALL: begin
                        res_d = '1;
                        ok_d  = 1'b1;
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else if (stop_bad && p_state_q != P_WAIT_SYNC) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= P_WAIT_SYNC;
            cmd_q     <= '0;
            idx_q     <= '0;
            res_q     <= '0;
            start_q   <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            res_q   <= res_d;
            start_q <= start_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            if (stop_bad) begin
                p_state_q <= P_WAIT_SYNC;
            end else if (byte_valid_q) begin
                unique case (p_state_q)
                    P_WAIT_SYNC: if (rx_byte_q == SYNC_BYTE) p_state_q <= P_GET_CMD;
                    P_GET_CMD: begin
                        cmd_q     <= rx_byte_q;
                        p_state_q <= P_GET_IDX;
                    end
                    P_GET_IDX: begin
                        idx_q     <= rx_byte_q;
                        p_state_q <= P_GET_CHK;
                    end
                    P_GET_CHK: p_state_q <= P_WAIT_SYNC;
                endcase
            end
        end
    end

    assign res       = res_q;
    assign start_all = start_q;
    assign cmd_ok    = ok_q;
    assign cmd_err   = err_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed frame table, hand-written corner sequences,
// then randomised traffic scored against a byte-queue model of the frame rules.
module tb_uart_cmd_rx;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int NUM      = 30;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int NV       = 13;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           RX  = 1'b1;
    logic [NUM-1:0] res;
    logic           start_all, cmd_ok, cmd_err, frame_err;

    always #5 clk = ~clk;

    uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_OF_MODULES(NUM)) dut (
        .clk(clk), .rst(rst), .RX(RX), .res(res), .start_all(start_all),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err), .frame_err(frame_err)
    );

    typedef struct packed {
        logic [NUM-1:0] res;
        logic           start;
        logic           ok;
        logic           err;
        logic           ferr;
        int             cyc;
    } ev_t;

    typedef struct packed {
        int             n;
        logic [47:0]    bytes;
        logic [5:0]     bad;
        logic [NUM-1:0] res;
        logic           st;
        logic           ok;
        logic           er;
        logic           fe;
        int             ne;
    } vec_t;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         last_start = 0;
    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] mq[$];
    vec_t       vecs[NV];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res != 0 || start_all || cmd_ok || cmd_err || frame_err) begin
            ev_t e;
            e.res = res; e.start = start_all; e.ok = cmd_ok;
            e.err = cmd_err; e.ferr = frame_err; e.cyc = cyc;
            got_q.push_back(e);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 byte starting at a falling clock edge; a bad stop bit is
    // followed by one bit-time of idle line.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        last_start = cyc;
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            RX = b[k];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_ok;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
    endtask

    function automatic ev_t eval_frame(input logic [7:0] cmd, input logic [7:0] idx,
                                       input logic [7:0] chk, input int anchor);
        ev_t e = '0;
        e.cyc = anchor;
        if (chk != (cmd ^ idx)) e.err = 1'b1;
        else if (cmd == 8'h01) begin e.start = 1'b1; e.ok = 1'b1; end
        else if (cmd == 8'h02) begin
            if (int'(idx) < NUM) begin e.res = NUM'(1) << idx; e.ok = 1'b1; end
            else e.err = 1'b1;
        end
        else if (cmd == 8'h03) begin e.res = '1; e.ok = 1'b1; end
        else e.err = 1'b1;
        return e;
    endfunction

    // Reference: bytes of the frame in progress are held in mq; a frame is
    // only started by A5, and a bad stop bit abandons whatever is held.
    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        ev_t e = '0;
        if (!stop_ok) begin
            e.ferr = 1'b1;
            e.err  = (mq.size() != 0);
            e.cyc  = last_start;
            exp_q.push_back(e);
            mq.delete();
        end else if (mq.size() == 0) begin
            if (b == 8'hA5) mq.push_back(b);
        end else begin
            mq.push_back(b);
            if (mq.size() == 4) begin
                exp_q.push_back(eval_frame(mq[1], mq[2], mq[3], last_start));
                mq.delete();
            end
        end
    endtask

    task automatic send_model(input logic [7:0] b, input logic stop_ok);
        send_byte(b, stop_ok);
        model_byte(b, stop_ok);
    endtask

    task automatic compare(input string tag);
        int n;
        int delta;
        int lim;
        repeat (12) @(negedge clk);
        check({tag, " pulse count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " outputs"},
                  64'({got_q[i].res, got_q[i].start, got_q[i].ok, got_q[i].err, got_q[i].ferr}),
                  64'({exp_q[i].res, exp_q[i].start, exp_q[i].ok, exp_q[i].err, exp_q[i].ferr}));
            // Pulse must land just after the stop-bit midpoint of the last byte.
            delta = got_q[i].cyc - exp_q[i].cyc;
            lim = (delta < 96) ? 96 : (delta > 101) ? 101 : delta;
            check({tag, " latency"}, 64'(delta), 64'(lim));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic vec_t mk(input int n, input logic [47:0] by, input logic [5:0] bad,
                                input logic [NUM-1:0] r, input logic st, input logic ok,
                                input logic er, input logic fe, input int ne);
        vec_t v;
        v.n = n; v.bytes = by; v.bad = bad; v.res = r;
        v.st = st; v.ok = ok; v.er = er; v.fe = fe; v.ne = ne;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(4, 48'hA5_01_00_01_00_00, 6'b000000, 30'h0,        1, 1, 0, 0, 1);
        vecs[1]  = mk(4, 48'hA5_02_07_05_00_00, 6'b000000, 30'h80,       0, 1, 0, 0, 1);
        vecs[2]  = mk(4, 48'hA5_02_1E_1C_00_00, 6'b000000, 30'h0,        0, 0, 1, 0, 1);
        vecs[3]  = mk(4, 48'hA5_03_00_03_00_00, 6'b000000, 30'h3FFFFFFF, 0, 1, 0, 0, 1);
        vecs[4]  = mk(4, 48'hA5_03_00_04_00_00, 6'b000000, 30'h0,        0, 0, 1, 0, 1);
        vecs[5]  = mk(3, 48'hA5_01_55_00_00_00, 6'b000100, 30'h0,        0, 0, 1, 1, 1);
        vecs[6]  = mk(4, 48'hA5_01_00_01_00_00, 6'b000000, 30'h0,        1, 1, 0, 0, 1);
        vecs[7]  = mk(6, 48'h00_FF_A5_02_00_02, 6'b000000, 30'h1,        0, 1, 0, 0, 1);
        vecs[8]  = mk(4, 48'hA5_04_00_04_00_00, 6'b000000, 30'h0,        0, 0, 1, 0, 1);
        vecs[9]  = mk(4, 48'hA5_02_1D_1F_00_00, 6'b000000, 30'h20000000, 0, 1, 0, 0, 1);
        vecs[10] = mk(1, 48'h33_00_00_00_00_00, 6'b000001, 30'h0,        0, 0, 0, 1, 1);
        vecs[11] = mk(4, 48'hA5_01_7E_7F_00_00, 6'b000000, 30'h0,        1, 1, 0, 0, 1);
        vecs[12] = mk(4, 48'hA5_01_00_00_00_00, 6'b000000, 30'h0,        0, 0, 1, 0, 1);

        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({res, start_all, cmd_ok, cmd_err, frame_err}), 64'd0);
        rst = 1'b0;
        got_q.delete();
        repeat (200) @(negedge clk);
        check("idle quiet", 64'(got_q.size()), 64'd0);

        for (int v = 0; v < NV; v++) begin
            ev_t e;
            for (int k = 0; k < vecs[v].n; k++)
                send_byte(vecs[v].bytes[47 - 8*k -: 8], !vecs[v].bad[k]);
            if (vecs[v].ne == 1) begin
                e.res = vecs[v].res; e.start = vecs[v].st; e.ok = vecs[v].ok;
                e.err = vecs[v].er; e.ferr = vecs[v].fe; e.cyc = last_start;
                exp_q.push_back(e);
            end
            compare($sformatf("vec%0d", v));
        end

        // Short low glitch must be rejected at the start-bit check.
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (30) @(negedge clk);
        compare("glitch");

        // Reset between SYNC/CMD and IDX/CHK discards the partial frame.
        send_model(8'hA5, 1'b1);
        send_model(8'h02, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        send_model(8'h07, 1'b1);
        send_model(8'h05, 1'b1);
        compare("reset midframe");

        for (int it = 0; it < 30; it++) begin
            logic [7:0] fr[4];
            int         nj;
            logic [7:0] j;
            int         sel;
            nj = $urandom_range(0, 2);
            for (int k = 0; k < nj; k++) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'hA4;
                send_model(j, $urandom_range(0, 7) != 0);
            end
            sel = $urandom_range(0, 4);
            fr[0] = 8'hA5;
            fr[1] = (sel < 4) ? 8'(sel) : 8'($urandom);
            fr[2] = (fr[1] == 8'h02) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            fr[3] = ($urandom_range(0, 3) != 0) ? (fr[1] ^ fr[2]) : 8'($urandom);
            for (int k = 0; k < 4; k++) begin
                logic sok;
                sok = ($urandom_range(0, 15) != 0);
                send_model(fr[k], sok);
                if (!sok) break;
            end
            compare($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Host-to-FPGA command receiver: the inbound end of the serial link whose outbound end streams search results on `TX`. Deserialises 8N1 UART bytes on `RX` and parses fixed 4-byte command frames. Valid frames become single-cycle control pulses: a global start and per-module or global `ext_res` resets. The block sits in the top level beside the result interface and drives the search-module array.

## Interface
- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer division, truncated; 434 at defaults; must be ≥ 4).
- `NUM_OF_MODULES`, 30, number of search modules addressed (1..255).

- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RX`  in  1  asynchronous UART line; idles high.
- `res`  out  NUM_OF_MODULES  per-module reset pulses (bit i → module i `ext_res`).
- `start_all`  out  1  one-cycle start pulse to every module.
- `cmd_ok`  out  1  one-cycle pulse for each accepted frame.
- `cmd_err`  out  1  one-cycle pulse for each rejected frame.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.

## Operation
- **Input synchronizer:** `RX` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Bit receiver FSM:** states IDLE, START, DATA, STOP.
  - IDLE: wait for synchronized RX = 0, then go to START and clear the bit counter.
  - START: count `CLKS_PER_BIT/2` cycles, then resample. If RX = 0, go to DATA. If RX = 1 (glitch), return to IDLE with no output.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, shifted into a byte register.
  - STOP: sample once after `CLKS_PER_BIT` cycles. RX = 1 raises internal `byte_valid` for one cycle. RX = 0 pulses `frame_err` and discards the byte. Both cases return to IDLE.
- **Frame format:** SYNC = 0xA5, CMD, IDX, CHK, where CHK = CMD XOR IDX.
- **Parser FSM:** states WAIT_SYNC, GET_CMD, GET_IDX, GET_CHK. It advances only on `byte_valid`.
  - WAIT_SYNC: any byte other than 0xA5 is ignored silently.
  - GET_CMD and GET_IDX latch their byte and advance.
  - GET_CHK evaluates the frame and always returns to WAIT_SYNC.
- **Command decode** (frame evaluated in GET_CHK):
  - 0x01: pulse `start_all`. IDX is ignored but still covered by the checksum.
  - 0x02: pulse `res[IDX]` only. Requires IDX < NUM_OF_MODULES.
  - 0x03: pulse all bits of `res`.
  - Valid frame: the command's outputs and `cmd_ok` pulse together for exactly one cycle.
  - Invalid frame (checksum mismatch, unknown CMD, or IDX out of range for 0x02): only `cmd_err` pulses. `res` and `start_all` stay 0.
- **Framing error mid-frame** (parser not in WAIT_SYNC): pulse `cmd_err` in the same cycle as `frame_err` and force the parser to WAIT_SYNC.
- **Back-to-back frames:** supported with no idle gap. The parser has no byte-to-byte timeout.
- **Reset:** `rst` at any point, including mid-byte or mid-frame, returns both FSMs to IDLE/WAIT_SYNC and clears counters and latched bytes. The next cycle's outputs are 0. No partially received frame survives reset.

## Timing
- **Reset values:** `res` = 0, `start_all` = 0, `cmd_ok` = 0, `cmd_err` = 0, `frame_err` = 0. All outputs are registered.
- **Input latency:** 2 cycles from the `RX` pin to the synchronized value.
- **Start and data sampling:** the start bit is confirmed `CLKS_PER_BIT/2` cycles after the synchronized falling edge. Data bit k is sampled `(k+1)*CLKS_PER_BIT` cycles after start confirmation.
- **`byte_valid`:** asserts 1 cycle after the stop-bit sample.
- **Command outputs:** `res`, `start_all`, `cmd_ok` and `cmd_err` assert 1 cycle after the CHK byte's `byte_valid`.
- **`frame_err`:** asserts 1 cycle after the failing stop-bit sample.
- **Pulse width:** every output pulse lasts exactly 1 cycle. Outputs never assert in two consecutive cycles for one frame.
- **Next byte:** the receiver is back in IDLE in time to catch a start bit that begins immediately after the stop bit. The stop bit is sampled mid-bit, leaving ≥ `CLKS_PER_BIT/2` cycles of margin.

## Test plan
Bench parameters: CLK_FREQ = 1_000_000, BAUD = 100_000 (10 clocks/bit), NUM_OF_MODULES = 30.
- **Reset check:** assert `rst` for 3 cycles with RX = 1 → all outputs 0. No pulses for 200 idle cycles.
- **Start all:** send A5 01 00 01 → exactly one cycle with `start_all` = 1 and `cmd_ok` = 1, 1 cycle after the last `byte_valid`; `res` = 0.
- **Module reset and out-of-range index:**
  - Send A5 02 07 05 → `res` = 0x00000080 for one cycle, plus `cmd_ok`.
  - Send A5 02 1E 1C → `cmd_err` only (IDX 30 is out of range).
- **Reset all and bad checksum:**
  - Send A5 03 00 03 → `res` = 0x3FFFFFFF for one cycle.
  - Send A5 03 00 04 → `cmd_err` only.
- **Framing error and glitch:**
  - Send A5 01, then a byte with stop bit = 0 → `frame_err` and `cmd_err` in the same cycle.
  - Then send A5 01 00 01 → `start_all` pulses.
  - A 3-cycle low glitch on RX → no output.
- **Reset mid-frame and leading junk:**
  - Send A5 02, assert `rst` for one cycle, then send 07 05 → no `res` and no `cmd_err`.
  - Send 00 FF A5 02 00 02 → `res[0]` pulses once.
